// File: rtl/fifo_pkg.sv
// Shared types and helpers for the async FIFO write side.
// Holds the admission FSM encoding, depth derivation and gray decode.
package fifo_pkg;

   localparam int unsigned ADDRSIZE_DEF = 4;
   localparam int unsigned GRAY_MAXW    = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_STREAM = 2'd2,
      ST_DRAIN  = 2'd3
   } wr_state_e;

   function automatic int unsigned fifo_depth(input int unsigned addrsize);
      return 32'd1 << addrsize;
   endfunction

   // Zero-extended gray codes decode correctly, so one width serves every pointer size.
   function automatic logic [GRAY_MAXW-1:0] gray2bin(input logic [GRAY_MAXW-1:0] g);
      logic [GRAY_MAXW-1:0] b;
      b = g;
      for (int i = GRAY_MAXW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_level_calc.sv
// Write-domain occupancy: decodes both gray pointers, folds in the in-flight write,
// and exposes free space combinationally plus registered level / almost-full.
module fifo_level_calc
   import fifo_pkg::*;
#(
   parameter int unsigned ADDRSIZE  = 4,
   parameter int unsigned AF_THRESH = 12
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic [ADDRSIZE:0]   wptr,
   input  logic [ADDRSIZE:0]   wq2_rptr,
   input  logic                winc,
   output logic [ADDRSIZE:0]   free_c,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                walmost_full
);

   localparam int unsigned PW    = ADDRSIZE + 1;
   localparam int unsigned DEPTH = fifo_depth(ADDRSIZE);

   logic [PW-1:0] wptr_bin;
   logic [PW-1:0] rptr_bin;
   logic [PW-1:0] lvl;
   logic [PW:0]   lvl_eff;
   logic [PW-1:0] lvl_sat;

   assign wptr_bin = PW'(gray2bin(GRAY_MAXW'(wptr)));
   assign rptr_bin = PW'(gray2bin(GRAY_MAXW'(wq2_rptr)));

   // Modulo subtract handles pointer wrap, including a completely full FIFO.
   always_comb begin
      lvl     = wptr_bin - rptr_bin;
      lvl_eff = {1'b0, lvl} + (PW+1)'(winc);
      lvl_sat = (lvl_eff > (PW+1)'(DEPTH)) ? PW'(DEPTH) : lvl_eff[PW-1:0];
      free_c  = PW'(DEPTH) - lvl_sat;
   end

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         wlevel       <= '0;
         walmost_full <= 1'b0;
      end else begin
         wlevel       <= lvl_sat;
         walmost_full <= (lvl_sat >= PW'(AF_THRESH));
      end
   end

endmodule

// File: rtl/wfifo_burst_wr_ctrl.sv
// Burst admission in front of the FIFO write-pointer stage: a burst streams only
// once the whole burst is known to fit; malformed framing is drained and flagged.
module wfifo_burst_wr_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned ADDRSIZE  = 4,
   parameter int unsigned DSIZE     = 8,
   parameter int unsigned AF_THRESH = 12
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DSIZE-1:0]    s_data,
   input  logic                s_sop,
   input  logic [ADDRSIZE:0]   s_len,
   input  logic                s_last,
   output logic                winc,
   output logic [DSIZE-1:0]    wdata,
   input  logic                wfull,
   input  logic [ADDRSIZE:0]   wptr,
   input  logic [ADDRSIZE:0]   wq2_rptr,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                walmost_full,
   output logic                err_len
);

   localparam int unsigned LW    = ADDRSIZE + 1;
   localparam int unsigned DEPTH = fifo_depth(ADDRSIZE);

   wr_state_e     state_q;
   wr_state_e     state_d;
   logic [LW-1:0] rem_q;
   logic [LW-1:0] rem_d;
   logic          err_d;
   logic          wr_d;
   logic [LW-1:0] free_c;

   fifo_level_calc #(
      .ADDRSIZE  (ADDRSIZE),
      .AF_THRESH (AF_THRESH)
   ) u_level (
      .wclk         (wclk),
      .wrst         (wrst),
      .wptr         (wptr),
      .wq2_rptr     (wq2_rptr),
      .winc         (winc),
      .free_c       (free_c),
      .wlevel       (wlevel),
      .walmost_full (walmost_full)
   );

   always_ff @(posedge wclk or posedge wrst) begin
      if (wrst) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         err_len <= 1'b0;
         winc    <= 1'b0;
         wdata   <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         err_len <= err_d;
         winc    <= wr_d;
         if (wr_d) begin
            wdata <= s_data;
         end
      end
   end

   // rem_q doubles as the latched burst length while waiting for space.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      err_d   = err_len;
      wr_d    = 1'b0;
      s_ready = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (s_valid && s_sop) begin
               rem_d = s_len;
               if ((s_len == '0) || (s_len > LW'(DEPTH))) begin
                  err_d   = 1'b1;
                  state_d = ST_DRAIN;
               end else if (free_c >= s_len) begin
                  state_d = ST_STREAM;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (free_c >= rem_q) begin
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            s_ready = ~wfull;
            if (s_valid && !wfull) begin
               wr_d  = 1'b1;
               rem_d = rem_q - LW'(1);
               if (s_last) begin
                  state_d = ST_IDLE;
                  if (rem_q != LW'(1)) begin
                     err_d = 1'b1;
                  end
               end else if (rem_q == LW'(1)) begin
                  err_d   = 1'b1;
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            s_ready = 1'b1;
            if (s_valid && s_last) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_wfifo_burst_wr_ctrl.sv
// Directed bench for wfifo_burst_wr_ctrl with a small write-pointer stage model.
module tb_wfifo_burst_wr_ctrl;

   logic       wclk;
   logic       wrst;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       s_sop;
   logic [4:0] s_len;
   logic       s_last;
   logic       winc;
   logic [7:0] wdata;
   logic       wfull;
   logic [4:0] wptr;
   logic [4:0] wq2_rptr;
   logic [4:0] wlevel;
   logic       walmost_full;
   logic       err_len;

   logic [4:0] wbin;
   logic [4:0] rbin;
   logic       load;
   logic [4:0] load_val;
   logic       clr;

   int         total;
   int         bad;
   int         winc_cnt;
   int         run;
   int         max_run;
   logic [7:0] last_wd;

   wfifo_burst_wr_ctrl #(
      .ADDRSIZE  (4),
      .DSIZE     (8),
      .AF_THRESH (12)
   ) dut (
      .wclk         (wclk),
      .wrst         (wrst),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .s_sop        (s_sop),
      .s_len        (s_len),
      .s_last       (s_last),
      .winc         (winc),
      .wdata        (wdata),
      .wfull        (wfull),
      .wptr         (wptr),
      .wq2_rptr     (wq2_rptr),
      .wlevel       (wlevel),
      .walmost_full (walmost_full),
      .err_len      (err_len)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   // Write-pointer stage model: binary counter with gray outputs.
   always @(posedge wclk) begin
      if (load) wbin <= load_val;
      else if (winc) wbin <= wbin + 5'd1;
   end
   assign wptr     = wbin ^ (wbin >> 1);
   assign wq2_rptr = rbin ^ (rbin >> 1);
   assign wfull    = ((wbin - rbin) == 5'd16);

   always @(negedge wclk) begin
      if (clr) begin
         winc_cnt = 0; run = 0; max_run = 0; last_wd = 8'h00;
      end else if (winc) begin
         winc_cnt = winc_cnt + 1;
         run      = run + 1;
         if (run > max_run) max_run = run;
         last_wd  = wdata;
      end else begin
         run = 0;
      end
   end

   typedef struct {
      logic [4:0] len;
      int         nbeats;
      int         lastpos;
      logic [4:0] init_w;
      logic [4:0] init_r;
      int         exp_writes;
      logic       exp_err;
      logic [4:0] exp_level;
      logic       exp_af;
      logic [7:0] exp_last;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge wclk); #1;
      end
   endtask

   task automatic start_row(input logic [4:0] w, input logic [4:0] r);
      wrst = 1'b1; clr = 1'b1; load = 1'b1; load_val = w; rbin = r;
      s_valid = 1'b0; s_sop = 1'b0; s_last = 1'b0; s_len = 5'd0; s_data = 8'h00;
      step(2);
      wrst = 1'b0; load = 1'b0; clr = 1'b0;
      step(1);
   endtask

   task automatic send(input logic [4:0] len, input int nbeats, input int lastpos,
                       input bit chk_lat, output int stalls);
      int w;
      stalls = 0;
      for (int b = 1; b <= nbeats; b++) begin
         s_valid = 1'b1; s_sop = (b == 1); s_len = len;
         s_last = (b == lastpos); s_data = 8'(8'h40 + b);
         w = 0;
         forever begin
            @(negedge wclk);
            if (s_ready) break;
            w++;
            if (w >= 100) break;
            @(posedge wclk); #1;
         end
         if (w >= 100) begin
            check("beat_timeout", 32'(b), 32'(0));
            s_valid = 1'b0; s_sop = 1'b0; s_last = 1'b0;
            return;
         end
         if (b > 1) stalls += w;
         if (chk_lat && b == 1) check("lat_before", 32'(winc), 32'(0));
         @(posedge wclk); #1;
         if (chk_lat && b == 1) check("lat_after", 32'(winc), 32'(1));
      end
      s_valid = 1'b0; s_sop = 1'b0; s_last = 1'b0;
   endtask

   initial begin
      int stalls;
      total = 0; bad = 0;
      //            len    nb  lp  w      r      wr err   lvl    af    last
      vecs[0] = '{5'd16, 16, 16, 5'd0,  5'd0,  16, 1'b0, 5'd16, 1'b1, 8'h50};
      vecs[1] = '{5'd0,   3,  3, 5'd0,  5'd0,   0, 1'b1, 5'd0,  1'b0, 8'h00};
      vecs[2] = '{5'd17,  4,  4, 5'd0,  5'd0,   0, 1'b1, 5'd0,  1'b0, 8'h00};
      vecs[3] = '{5'd4,   2,  2, 5'd0,  5'd0,   2, 1'b1, 5'd2,  1'b0, 8'h42};
      vecs[4] = '{5'd3,   5,  5, 5'd0,  5'd0,   3, 1'b1, 5'd3,  1'b0, 8'h43};
      vecs[5] = '{5'd5,   5,  5, 5'd30, 5'd28,  5, 1'b0, 5'd7,  1'b0, 8'h45};
      vecs[6] = '{5'd1,   1,  1, 5'd11, 5'd0,   1, 1'b0, 5'd12, 1'b1, 8'h41};
      vecs[7] = '{5'd1,   1,  1, 5'd9,  5'd0,   1, 1'b0, 5'd10, 1'b0, 8'h41};
      vecs[8] = '{5'd1,   1,  1, 5'd15, 5'd0,   1, 1'b0, 5'd16, 1'b1, 8'h41};

      // Reset state
      start_row(5'd0, 5'd0);
      check("rst_s_ready", 32'(s_ready), 32'(0));
      check("rst_winc", 32'(winc), 32'(0));
      check("rst_wlevel", 32'(wlevel), 32'(0));
      check("rst_err", 32'(err_len), 32'(0));
      check("rst_af", 32'(walmost_full), 32'(0));
      check("rst_wdata", 32'(wdata), 32'(0));

      for (int i = 0; i < 9; i++) begin
         start_row(vecs[i].init_w, vecs[i].init_r);
         send(vecs[i].len, vecs[i].nbeats, vecs[i].lastpos, vecs[i].exp_writes > 0, stalls);
         step(4);
         check($sformatf("v%0d_writes", i), 32'(winc_cnt), 32'(vecs[i].exp_writes));
         check($sformatf("v%0d_run", i), 32'(max_run), 32'(vecs[i].exp_writes));
         check($sformatf("v%0d_err", i), 32'(err_len), 32'(vecs[i].exp_err));
         check($sformatf("v%0d_level", i), 32'(wlevel), 32'(vecs[i].exp_level));
         check($sformatf("v%0d_af", i), 32'(walmost_full), 32'(vecs[i].exp_af));
         check($sformatf("v%0d_lastdata", i), 32'(last_wd), 32'(vecs[i].exp_last));
         check($sformatf("v%0d_stalls", i), 32'(stalls), 32'(0));
      end

      // Level 10, len 8: must wait until the reader frees two words
      start_row(5'd10, 5'd0);
      s_valid = 1'b1; s_sop = 1'b1; s_len = 5'd8; s_last = 1'b0; s_data = 8'h41;
      step(5);
      check("wait_s_ready", 32'(s_ready), 32'(0));
      check("wait_writes", 32'(winc_cnt), 32'(0));
      check("wait_level", 32'(wlevel), 32'(10));
      rbin = 5'd2;
      send(5'd8, 8, 8, 1'b1, stalls);
      step(4);
      check("wait_total_writes", 32'(winc_cnt), 32'(8));
      check("wait_stalls", 32'(stalls), 32'(0));
      check("wait_level_end", 32'(wlevel), 32'(16));
      check("wait_af", 32'(walmost_full), 32'(1));
      check("wait_err", 32'(err_len), 32'(0));

      // Pointer wrap: wptr 30->3, rptr 28->1
      start_row(5'd30, 5'd28);
      send(5'd5, 5, 5, 1'b0, stalls);
      step(4);
      check("wrap_level7", 32'(wlevel), 32'(7));
      rbin = 5'd1;
      step(2);
      check("wrap_level2", 32'(wlevel), 32'(2));
      check("wrap_af", 32'(walmost_full), 32'(0));

      // Reset asserted in the middle of a stream
      start_row(5'd0, 5'd0);
      s_valid = 1'b1; s_sop = 1'b1; s_len = 5'd16; s_last = 1'b0; s_data = 8'h77;
      step(4);
      check("mid_s_ready", 32'(s_ready), 32'(1));
      check("mid_winc", 32'(winc), 32'(1));
      check("mid_wlevel", 32'(wlevel), 32'(2));
      wrst = 1'b1;
      #1;
      check("mid_rst_s_ready", 32'(s_ready), 32'(0));
      check("mid_rst_winc", 32'(winc), 32'(0));
      check("mid_rst_wlevel", 32'(wlevel), 32'(0));
      check("mid_rst_af", 32'(walmost_full), 32'(0));
      check("mid_rst_err", 32'(err_len), 32'(0));
      check("mid_rst_wdata", 32'(wdata), 32'(0));
      s_valid = 1'b0; s_sop = 1'b0;
      step(2);
      wrst = 1'b0;
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule
